// File: rtl/clk_rst_seq.sv
// Reset sequencer behind the DCM: pulses DCM RST, qualifies LOCKED, then releases DDR/MIG and system resets.
// Define CLKRST_CALIB_WAIT_EN to hold sys_rst_n until MIG calibration completes.
module clk_rst_seq #(
  parameter int RST_PULSE    = 8,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       calib_done,
  output logic       dcm_rst,
  output logic       ddr_rst_n,
  output logic       sys_rst_n,
  output logic [7:0] retry_cnt,
  output logic       lock_lost,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_DCM_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_CALIB     = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_PULSE_END   = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] C_STABLE_END  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);

`ifdef CLKRST_CALIB_WAIT_EN
  localparam state_t S_STABLE_EXIT = S_CALIB;
`else
  localparam state_t S_STABLE_EXIT = S_RUN;
`endif

  logic [1:0]       r_rst_sync;
  logic [1:0]       r_lock_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dcm_rst;
  logic             r_ddr_rst_n;
  logic             r_sys_rst_n;
  logic [7:0]       r_retry;
  logic             r_lost;

  logic             w_rst_rel;
  logic             w_locked_s;
  logic             w_calib_s;
  state_t           w_state_nxt;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_retry_nxt;
  logic             w_lost_nxt;
  logic             w_dcm_nxt;
  logic             w_ddr_nxt;
  logic             w_sys_nxt;

  // Reset asserts asynchronously but the FSM only starts two edges after rst_n deasserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_rel = r_rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lock_sync <= '0;
    else        r_lock_sync <= {r_lock_sync[0], locked};
  end
  assign w_locked_s = r_lock_sync[1];

`ifdef CLKRST_CALIB_WAIT_EN
  logic [1:0] r_calib_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_calib_sync <= '0;
    else        r_calib_sync <= {r_calib_sync[0], calib_done};
  end
  assign w_calib_s = r_calib_sync[1];
`else
  logic w_unused_calib;
  assign w_unused_calib = calib_done;
  assign w_calib_s      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_inc   = 1'b0;
    w_retry_nxt = r_retry;
    w_lost_nxt  = 1'b0;
    case (r_state)
      S_DCM_RST: begin
        if (r_cnt == C_PULSE_END) w_state_nxt = S_WAIT_LOCK;
        else                      w_cnt_inc   = 1'b1;
      end
      S_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as a lock.
        if (w_locked_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == C_TIMEOUT_END) begin
          w_state_nxt = S_DCM_RST;
          if (r_retry != 8'hFF) w_retry_nxt = r_retry + 8'd1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!w_locked_s)                w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == C_STABLE_END) w_state_nxt = S_STABLE_EXIT;
        else                            w_cnt_inc   = 1'b1;
      end
`ifdef CLKRST_CALIB_WAIT_EN
      S_CALIB: begin
        if (!w_locked_s) begin
          w_state_nxt = S_DCM_RST;
          w_lost_nxt  = 1'b1;
        end else if (w_calib_s) begin
          w_state_nxt = S_RUN;
        end
      end
`endif
      S_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = S_DCM_RST;
          w_lost_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_DCM_RST;
    endcase

    w_cnt_nxt = (w_state_nxt != r_state) ? '0 : (w_cnt_inc ? r_cnt + 1'b1 : r_cnt);
    // Outputs decode the next state so the reset ordering holds by construction.
    w_dcm_nxt = (w_state_nxt == S_DCM_RST);
    w_ddr_nxt = (w_state_nxt == S_CALIB) || (w_state_nxt == S_RUN);
    w_sys_nxt = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_DCM_RST;
      r_cnt       <= '0;
      r_dcm_rst   <= 1'b1;
      r_ddr_rst_n <= 1'b0;
      r_sys_rst_n <= 1'b0;
      r_retry     <= '0;
      r_lost      <= 1'b0;
    end else if (w_rst_rel) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dcm_rst   <= w_dcm_nxt;
      r_ddr_rst_n <= w_ddr_nxt;
      r_sys_rst_n <= w_sys_nxt;
      r_retry     <= w_retry_nxt;
      r_lost      <= w_lost_nxt;
    end
  end

  assign dcm_rst   = r_dcm_rst;
  assign ddr_rst_n = r_ddr_rst_n;
  assign sys_rst_n = r_sys_rst_n;
  assign retry_cnt = r_retry;
  assign lock_lost = r_lost;
  assign state     = r_state;

endmodule
